spi_flash_snoop: RTL

Passive monitor on the ESP32-to-SPI-flash passthrough. It samples `esp_clk`, `esp_cs_n` and `esp_mosi` in the 27 MHz domain and decodes each flash transaction into an opcode, an optional 24-bit address and a data byte count. It raises a sticky flag whenever a program or erase command reaches the flash. `timed_restart` and the status-LED logic consume its strobes in place of the raw chip select. It never drives the SPI bus; the passthrough wiring is unchanged.

---
 rtl/spi_flash_snoop.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_flash_snoop.sv
// Passive SPI flash transaction decoder: synchronizes SCK/CS/MOSI into the clk domain
// and reports opcode, address, data byte count and a sticky program/erase flag.
`timescale 1ns/1ps
module spi_flash_snoop #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             esp_clk,
    input  logic             esp_cs_n,
    input  logic             esp_mosi,
    input  logic             clr_write_seen,
    output logic             busy,
    output logic             cmd_valid,
    output logic [7:0]       cmd_opcode,
    output logic [23:0]      cmd_addr,
    output logic             cmd_has_addr,
    output logic             xfer_done,
    output logic             xfer_err,
    output logic [CNT_W-1:0] xfer_bytes,
    output logic             write_seen
);

    typedef enum logic [2:0] {StWaitHi, StIdle, StCmd, StAddr, StData} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d1, sck_d2, cs_d1, cs_d2, mosi_d1;
    logic                   sck_rise, cs_rise, cs_fall;
    logic [7:0]             next_byte;

    state_t           state;
    logic [22:0]      shift;
    logic [4:0]       bit_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [7:0]       op_q;

    function automatic logic is_addr_op(input logic [7:0] op);
        return op inside {8'h02, 8'h03, 8'h0B, 8'h20, 8'h52, 8'hD8};
    endfunction

    function automatic logic is_write_op(input logic [7:0] op);
        return op inside {8'h02, 8'h20, 8'h52, 8'hD8, 8'hC7, 8'h60};
    endfunction

    // MOSI takes the same path length as SCK so the bit is aligned with its edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_d1    <= 1'b0;
            sck_d2    <= 1'b0;
            cs_d1     <= 1'b0;
            cs_d2     <= 1'b0;
            mosi_d1   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], esp_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], esp_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], esp_mosi};
            sck_d1    <= sck_sync[SYNC_STAGES-1];
            sck_d2    <= sck_d1;
            cs_d1     <= cs_sync[SYNC_STAGES-1];
            cs_d2     <= cs_d1;
            mosi_d1   <= mosi_sync[SYNC_STAGES-1];
        end
    end

    assign sck_rise  = sck_d1 & ~sck_d2;
    assign cs_rise   = cs_d1 & ~cs_d2;
    assign cs_fall   = ~cs_d1 & cs_d2;
    assign next_byte = {shift[6:0], mosi_d1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StWaitHi;
            shift        <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            op_q         <= '0;
            busy         <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_opcode   <= '0;
            cmd_addr     <= '0;
            cmd_has_addr <= 1'b0;
            xfer_done    <= 1'b0;
            xfer_err     <= 1'b0;
            xfer_bytes   <= '0;
            write_seen   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            xfer_done <= 1'b0;
            // A same-cycle set below overrides this clear.
            if (clr_write_seen) write_seen <= 1'b0;

            case (state)
                StWaitHi: if (cs_d1) state <= StIdle;
                StIdle: begin
                    if (cs_fall) begin
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= StCmd;
                    end
                end
                StCmd, StAddr, StData: begin
                    if (cs_rise) begin
                        xfer_done  <= 1'b1;
                        xfer_err   <= (state != StData) || (bit_cnt != 5'd0);
                        xfer_bytes <= byte_cnt;
                        busy       <= 1'b0;
                        state      <= StIdle;
                    end else if (sck_rise) begin
                        shift   <= {shift[21:0], mosi_d1};
                        bit_cnt <= bit_cnt + 5'd1;
                        case (state)
                            StCmd: begin
                                if (bit_cnt == 5'd7) begin
                                    op_q    <= next_byte;
                                    bit_cnt <= '0;
                                    if (is_addr_op(next_byte)) begin
                                        state <= StAddr;
                                    end else begin
                                        cmd_valid    <= 1'b1;
                                        cmd_opcode   <= next_byte;
                                        cmd_has_addr <= 1'b0;
                                        if (is_write_op(next_byte)) write_seen <= 1'b1;
                                        state <= StData;
                                    end
                                end
                            end
                            StAddr: begin
                                if (bit_cnt == 5'd23) begin
                                    cmd_valid    <= 1'b1;
                                    cmd_opcode   <= op_q;
                                    cmd_addr     <= {shift, mosi_d1};
                                    cmd_has_addr <= 1'b1;
                                    if (is_write_op(op_q)) write_seen <= 1'b1;
                                    bit_cnt <= '0;
                                    state   <= StData;
                                end
                            end
                            default: begin
                                if (bit_cnt == 5'd7) begin
                                    bit_cnt <= '0;
                                    if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: state <= StWaitHi;
            endcase
        end
    end

endmodule
